ctrl_pipe: RTL and testbench
============================

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- Bus_i  in  8  decoded ID-stage control word, {RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite, ExtOp, ALUOp[1:0]} = bits [7..0].
- Valid_i  in  1  ID stage holds a real instruction.
- RS_i  in  5  ID rs field.
- RT_i  in  5  ID rt field.
- RD_i  in  5  ID rd field.
- Flush_i  in  1  discard the ID instruction (taken branch or jump).
- Stall_o  out  1  load-use hazard; upstream holds PC and IF/ID.
- EX_ALUSrc_o  out  1  EX-stage ALUSrc.
- EX_ExtOp_o  out  1  EX-stage ExtOp.
- EX_ALUOp_o  out  2  EX-stage ALUOp.
- EX_WriteReg_o  out  5  EX destination register.
- FwdA_o  out  2  ALU operand A forward select.
- FwdB_o  out  2  ALU operand B forward select.
- MEM_MemWrite_o  out  1  data-memory write enable.
- MEM_MemRead_o  out  1  data-memory read (MemtoReg in MEM).
- MEM_WriteReg_o  out  5  MEM destination register.
- WB_RegWrite_o  out  1  register-file write enable.
- WB_MemtoReg_o  out  1  write-back mux select.
- WB_WriteReg_o  out  5  register-file write address.

REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.

Function
REQ-003 The block SHALL hold three registered stages: EX {valid, ALUSrc, ExtOp, ALUOp, MemtoReg, RegWrite, MemWrite, rs, rt, WriteReg}, MEM {MemtoReg, RegWrite, MemWrite, WriteReg}, and WB {RegWrite, MemtoReg, WriteReg}.
REQ-004 A bubble SHALL be all stage fields zero.
REQ-005 On each clock edge, EX SHALL load from ID, with WriteReg = RegDst ? RD_i : RT_i.
REQ-006 On each clock edge, MEM SHALL load from EX and WB SHALL load from MEM; MEM and WB always advance.
REQ-007 EX SHALL load a bubble when any of the following holds: Valid_i = 0, Flush_i = 1, or Stall_o = 1.
REQ-008 Stage outputs SHALL be driven directly from stage registers with no combinational path from Bus_i.
- Latency from Bus_i to EX outputs: 1 cycle.
- Latency from Bus_i to MEM outputs: 2 cycles.
- Latency from Bus_i to WB outputs: 3 cycles.
REQ-009 Stall_o SHALL be combinational and asserted when all of the following hold: EX.valid, EX.MemtoReg, EX.RegWrite, EX.WriteReg != 0, Valid_i, not Flush_i, and EX.WriteReg equals RS_i or RT_i.
REQ-010 Stall_o SHALL last exactly one cycle per load-use pair: the inserted bubble clears the condition on the next cycle.
REQ-011 Flush_i SHALL have priority over Stall_o; with Flush_i = 1, Stall_o = 0 and EX receives a bubble.
REQ-012 FwdA_o SHALL be combinational and computed in priority order:
- 2'b10 if MEM.RegWrite, MEM.WriteReg != 0, and MEM.WriteReg == EX.rs;
- else 2'b01 if WB.RegWrite, WB.WriteReg != 0, and WB.WriteReg == EX.rs;
- else 2'b00.
REQ-013 FwdB_o SHALL use the same rule as FwdA_o with EX.rt in place of EX.rs.
REQ-014 When MEM and WB both match, MEM SHALL win (2'b10).
REQ-015 A destination of register 0 SHALL never cause forwarding or a stall, but the stage SHALL still carry it unchanged.
REQ-016 Undefined opcodes SHALL be treated as whatever Bus_i presents; the block performs no opcode checks.

Reset
REQ-017 While rst_i = 1, all three stages SHALL be bubbles immediately, independent of clk_i; all outputs SHALL be 0, including Stall_o, FwdA_o and FwdB_o.
REQ-018 Reset asserted mid-operation SHALL discard all in-flight instructions.
REQ-019 The first edge after rst_i falls SHALL load normally.

Verification
REQ-020 The bench SHALL drive R-type Bus_i = 8'h97 with RD_i = 3, RT_i = 4, Valid_i = 1 for one cycle; required response:
- EX_WriteReg_o = 3 and EX_ALUOp_o = 2'b11 after 1 edge;
- MEM_WriteReg_o = 3 after 2 edges;
- WB_RegWrite_o = 1 and WB_WriteReg_o = 3 after 3 edges.
REQ-021 The bench SHALL drive lw (Bus_i = 8'h74, RT_i = 8), then R-type with RS_i = 8 held in ID; required response:
- Stall_o = 1 for exactly one cycle;
- EX is a bubble during that cycle (EX_ALUOp_o = 0, EX_WriteReg_o = 0);
- when the consumer reaches EX, FwdA_o = 2'b01.
REQ-022 The bench SHALL drive R-type with RD_i = 5, followed directly by R-type with RS_i = RT_i = 5; required response: FwdA_o = FwdB_o = 2'b10 while the consumer is in EX.
REQ-023 The bench SHALL repeat the REQ-021 lw hazard with Flush_i = 1 on the consumer cycle; required response: Stall_o = 0, EX receives a bubble, and FwdA_o = 0 on the next cycle.
REQ-024 The bench SHALL drive R-type with RD_i = 0, followed by a consumer with RS_i = 0, and also lw with RT_i = 0 followed by RS_i = 0; required response: Stall_o = 0 and FwdA_o = 2'b00 throughout.
REQ-025 The bench SHALL assert rst_i asynchronously between edges while three instructions are in flight; required response: all outputs read 0 before the next edge, and an instruction issued after release appears in EX exactly 1 edge later.

Source files
------------

// File: rtl/ctrl_pipe_if.sv
// ID-to-pipeline control bundle: decoded ID control/register fields in, stage controls and hazard selects out.
interface ctrl_pipe_if;
    logic [7:0] Bus_i;
    logic       Valid_i;
    logic [4:0] RS_i;
    logic [4:0] RT_i;
    logic [4:0] RD_i;
    logic       Flush_i;
    logic       Stall_o;
    logic       EX_ALUSrc_o;
    logic       EX_ExtOp_o;
    logic [1:0] EX_ALUOp_o;
    logic [4:0] EX_WriteReg_o;
    logic [1:0] FwdA_o;
    logic [1:0] FwdB_o;
    logic       MEM_MemWrite_o;
    logic       MEM_MemRead_o;
    logic [4:0] MEM_WriteReg_o;
    logic       WB_RegWrite_o;
    logic       WB_MemtoReg_o;
    logic [4:0] WB_WriteReg_o;

    modport master (
        output Bus_i, Valid_i, RS_i, RT_i, RD_i, Flush_i,
        input  Stall_o, EX_ALUSrc_o, EX_ExtOp_o, EX_ALUOp_o, EX_WriteReg_o,
               FwdA_o, FwdB_o, MEM_MemWrite_o, MEM_MemRead_o, MEM_WriteReg_o,
               WB_RegWrite_o, WB_MemtoReg_o, WB_WriteReg_o
    );

    modport slave (
        input  Bus_i, Valid_i, RS_i, RT_i, RD_i, Flush_i,
        output Stall_o, EX_ALUSrc_o, EX_ExtOp_o, EX_ALUOp_o, EX_WriteReg_o,
               FwdA_o, FwdB_o, MEM_MemWrite_o, MEM_MemRead_o, MEM_WriteReg_o,
               WB_RegWrite_o, WB_MemtoReg_o, WB_WriteReg_o
    );
endinterface

// File: rtl/ctrl_pipe.sv
// EX/MEM/WB control pipeline with load-use stall detection and ALU operand forwarding selects.
module ctrl_pipe (
    input  logic        clk_i,
    input  logic        rst_i,
    ctrl_pipe_if.slave  pipe
);
    localparam int unsigned REG_W = 5;
    localparam int unsigned OP_W  = 2;

    typedef struct packed {
        logic             valid;
        logic             alu_src;
        logic             ext_op;
        logic [OP_W-1:0]  alu_op;
        logic             memto_reg;
        logic             reg_write;
        logic             mem_write;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] write_reg;
    } ex_t;

    typedef struct packed {
        logic             memto_reg;
        logic             reg_write;
        logic             mem_write;
        logic [REG_W-1:0] write_reg;
    } mem_t;

    typedef struct packed {
        logic             reg_write;
        logic             memto_reg;
        logic [REG_W-1:0] write_reg;
    } wb_t;

    ex_t  ex_d,  ex_q;
    mem_t mem_d, mem_q;
    wb_t  wb_d,  wb_q;
    logic stall_c;

    // Priority forward select: MEM result is younger than WB, so it wins.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                           input mem_t m, input wb_t w);
        logic [1:0] sel;
        sel = 2'b00;
        if (m.reg_write && (m.write_reg != '0) && (m.write_reg == src)) begin
            sel = 2'b10;
        end else if (w.reg_write && (w.write_reg != '0) && (w.write_reg == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Load in EX whose destination is read by the ID instruction.
    always_comb begin
        stall_c = ex_q.valid && ex_q.memto_reg && ex_q.reg_write &&
                  (ex_q.write_reg != '0) && pipe.Valid_i && !pipe.Flush_i &&
                  ((ex_q.write_reg == pipe.RS_i) || (ex_q.write_reg == pipe.RT_i));
    end

    always_comb begin
        ex_d = '0;
        if (pipe.Valid_i && !pipe.Flush_i && !stall_c) begin
            ex_d.valid     = 1'b1;
            ex_d.alu_src   = pipe.Bus_i[6];
            ex_d.memto_reg = pipe.Bus_i[5];
            ex_d.reg_write = pipe.Bus_i[4];
            ex_d.mem_write = pipe.Bus_i[3];
            ex_d.ext_op    = pipe.Bus_i[2];
            ex_d.alu_op    = pipe.Bus_i[1:0];
            ex_d.rs        = pipe.RS_i;
            ex_d.rt        = pipe.RT_i;
            ex_d.write_reg = pipe.Bus_i[7] ? pipe.RD_i : pipe.RT_i;
        end
        mem_d.memto_reg = ex_q.memto_reg;
        mem_d.reg_write = ex_q.reg_write;
        mem_d.mem_write = ex_q.mem_write;
        mem_d.write_reg = ex_q.write_reg;
        wb_d.reg_write  = mem_q.reg_write;
        wb_d.memto_reg  = mem_q.memto_reg;
        wb_d.write_reg  = mem_q.write_reg;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign pipe.Stall_o        = stall_c;
    assign pipe.EX_ALUSrc_o    = ex_q.alu_src;
    assign pipe.EX_ExtOp_o     = ex_q.ext_op;
    assign pipe.EX_ALUOp_o     = ex_q.alu_op;
    assign pipe.EX_WriteReg_o  = ex_q.write_reg;
    assign pipe.FwdA_o         = fwd_sel(ex_q.rs, mem_q, wb_q);
    assign pipe.FwdB_o         = fwd_sel(ex_q.rt, mem_q, wb_q);
    assign pipe.MEM_MemWrite_o = mem_q.mem_write;
    assign pipe.MEM_MemRead_o  = mem_q.memto_reg;
    assign pipe.MEM_WriteReg_o = mem_q.write_reg;
    assign pipe.WB_RegWrite_o  = wb_q.reg_write;
    assign pipe.WB_MemtoReg_o  = wb_q.memto_reg;
    assign pipe.WB_WriteReg_o  = wb_q.write_reg;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: vector table plus hand sequences for stall, flush, r0 and reset.
module tb_ctrl_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    ctrl_pipe_if pif ();

    ctrl_pipe u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .pipe  (pif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] bus;
        logic       valid;
        logic [4:0] rs, rt, rd;
        logic       flush;
        logic       stall;
        logic [1:0] aluop;
        logic [4:0] ex_wr;
        logic [1:0] fa, fb;
        logic [4:0] mem_wr;
        logic       wb_rw;
        logic [4:0] wb_wr;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drv(input logic [7:0] b, input logic v, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] d, input logic f);
        pif.Bus_i   = b;
        pif.Valid_i = v;
        pif.RS_i    = s;
        pif.RT_i    = t;
        pif.RD_i    = d;
        pif.Flush_i = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drv(8'h00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (3) tick();
    endtask

    function automatic logic [27:0] all_outs();
        return {pif.Stall_o, pif.EX_ALUSrc_o, pif.EX_ExtOp_o, pif.EX_ALUOp_o,
                pif.EX_WriteReg_o, pif.FwdA_o, pif.FwdB_o, pif.MEM_MemWrite_o,
                pif.MEM_MemRead_o, pif.MEM_WriteReg_o, pif.WB_RegWrite_o,
                pif.WB_MemtoReg_o, pif.WB_WriteReg_o};
    endfunction

    initial begin
        // bus valid rs rt rd flush | stall aluop ex_wr fa fb mem_wr wb_rw wb_wr
        vecs[0]  = '{8'h97, 1'b1, 5'd1, 5'd4, 5'd3, 1'b0, 1'b0, 2'd0, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 5'd0};
        vecs[1]  = '{8'h00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd3, 5'd3, 2'd0, 2'd0, 5'd0, 1'b0, 5'd0};
        vecs[2]  = '{8'h00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 5'd0, 2'd0, 2'd0, 5'd3, 1'b0, 5'd0};
        vecs[3]  = '{8'h97, 1'b1, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 2'd0, 5'd0, 2'd0, 2'd0, 5'd0, 1'b1, 5'd3};
        vecs[4]  = '{8'h97, 1'b1, 5'd5, 5'd5, 5'd6, 1'b0, 1'b0, 2'd3, 5'd5, 2'd0, 2'd0, 5'd0, 1'b0, 5'd0};
        vecs[5]  = '{8'h00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd3, 5'd6, 2'd2, 2'd2, 5'd5, 1'b0, 5'd0};
        vecs[6]  = '{8'h00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 5'd0, 2'd0, 2'd0, 5'd6, 1'b1, 5'd5};
        vecs[7]  = '{8'h97, 1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 2'd0, 5'd0, 2'd0, 2'd0, 5'd0, 1'b1, 5'd6};
        vecs[8]  = '{8'h97, 1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 2'd3, 5'd7, 2'd0, 2'd0, 5'd0, 1'b0, 5'd0};
        vecs[9]  = '{8'h97, 1'b1, 5'd7, 5'd1, 5'd2, 1'b0, 1'b0, 2'd3, 5'd7, 2'd0, 2'd0, 5'd7, 1'b0, 5'd0};
        vecs[10] = '{8'h00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd3, 5'd2, 2'd2, 2'd0, 5'd7, 1'b1, 5'd7};
        vecs[11] = '{8'h00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 5'd0, 2'd0, 2'd0, 5'd2, 1'b1, 5'd7};

        drv(8'h00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        check("reset_outputs", 32'(all_outs()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            drv(vecs[i].bus, vecs[i].valid, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].flush);
            #1;
            check($sformatf("v%0d_stall", i),  32'(pif.Stall_o),        32'(vecs[i].stall));
            check($sformatf("v%0d_aluop", i),  32'(pif.EX_ALUOp_o),     32'(vecs[i].aluop));
            check($sformatf("v%0d_ex_wr", i),  32'(pif.EX_WriteReg_o),  32'(vecs[i].ex_wr));
            check($sformatf("v%0d_fwda", i),   32'(pif.FwdA_o),         32'(vecs[i].fa));
            check($sformatf("v%0d_fwdb", i),   32'(pif.FwdB_o),         32'(vecs[i].fb));
            check($sformatf("v%0d_mem_wr", i), 32'(pif.MEM_WriteReg_o), 32'(vecs[i].mem_wr));
            check($sformatf("v%0d_wb_rw", i),  32'(pif.WB_RegWrite_o),  32'(vecs[i].wb_rw));
            check($sformatf("v%0d_wb_wr", i),  32'(pif.WB_WriteReg_o),  32'(vecs[i].wb_wr));
            tick();
        end

        // Load-use: lw r8 then consumer reading r8, held in ID across the stall.
        drain();
        drv(8'h74, 1'b1, 5'd0, 5'd8, 5'd0, 1'b0);
        tick();
        drv(8'h97, 1'b1, 5'd8, 5'd1, 5'd9, 1'b0);
        #1;
        check("lu_stall_c1", 32'(pif.Stall_o), 32'd1);
        check("lu_ex_wr_c1", 32'(pif.EX_WriteReg_o), 32'd8);
        tick();
        #1;
        check("lu_stall_c2", 32'(pif.Stall_o), 32'd0);
        check("lu_bubble_aluop", 32'(pif.EX_ALUOp_o), 32'd0);
        check("lu_bubble_wr", 32'(pif.EX_WriteReg_o), 32'd0);
        check("lu_mem_read", 32'(pif.MEM_MemRead_o), 32'd1);
        tick();
        drv(8'h00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        check("lu_stall_c3", 32'(pif.Stall_o), 32'd0);
        check("lu_ex_wr_c3", 32'(pif.EX_WriteReg_o), 32'd9);
        check("lu_fwda", 32'(pif.FwdA_o), 32'd1);
        check("lu_fwdb", 32'(pif.FwdB_o), 32'd0);
        check("lu_wb_m2r", 32'(pif.WB_MemtoReg_o), 32'd1);

        // Same hazard, but the consumer is flushed.
        drain();
        drv(8'h74, 1'b1, 5'd0, 5'd8, 5'd0, 1'b0);
        tick();
        drv(8'h97, 1'b1, 5'd8, 5'd1, 5'd9, 1'b1);
        #1;
        check("fl_stall", 32'(pif.Stall_o), 32'd0);
        tick();
        drv(8'h00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        check("fl_bubble_aluop", 32'(pif.EX_ALUOp_o), 32'd0);
        check("fl_bubble_wr", 32'(pif.EX_WriteReg_o), 32'd0);
        check("fl_fwda", 32'(pif.FwdA_o), 32'd0);
        tick();
        check("fl_fwda_next", 32'(pif.FwdA_o), 32'd0);

        // Register 0 destination: R-type rd=0 then consumer rs=0.
        drain();
        drv(8'h97, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        drv(8'h97, 1'b1, 5'd0, 5'd0, 5'd1, 1'b0);
        #1;
        check("r0_stall", 32'(pif.Stall_o), 32'd0);
        tick();
        drv(8'h00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        check("r0_fwda_mem", 32'(pif.FwdA_o), 32'd0);
        check("r0_fwdb_mem", 32'(pif.FwdB_o), 32'd0);
        tick();
        check("r0_fwda_wb", 32'(pif.FwdA_o), 32'd0);
        check("r0_wb_carry", 32'({pif.WB_RegWrite_o, pif.WB_WriteReg_o}), 32'h20);

        // Register 0 destination: lw rt=0 then consumer rs=0.
        drain();
        drv(8'h74, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        drv(8'h97, 1'b1, 5'd0, 5'd0, 5'd1, 1'b0);
        #1;
        check("r0lw_stall", 32'(pif.Stall_o), 32'd0);
        tick();
        drv(8'h00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        check("r0lw_fwda", 32'(pif.FwdA_o), 32'd0);
        check("r0lw_mem_read", 32'(pif.MEM_MemRead_o), 32'd1);

        // Asynchronous reset with three instructions in flight.
        drain();
        drv(8'h97, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        drv(8'h97, 1'b1, 5'd3, 5'd2, 5'd4, 1'b0);
        tick();
        drv(8'h97, 1'b1, 5'd4, 5'd3, 5'd5, 1'b0);
        tick();
        drv(8'h74, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
        #1;
        check("rs_pre_ex_wr", 32'(pif.EX_WriteReg_o), 32'd5);
        check("rs_pre_wb_wr", 32'(pif.WB_WriteReg_o), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("rs_async_outs", 32'(all_outs()), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        drv(8'h97, 1'b1, 5'd0, 5'd0, 5'd6, 1'b0);
        #1;
        check("rs_rel_ex_wr_pre", 32'(pif.EX_WriteReg_o), 32'd0);
        tick();
        check("rs_rel_ex_wr", 32'(pif.EX_WriteReg_o), 32'd6);
        check("rs_rel_aluop", 32'(pif.EX_ALUOp_o), 32'd3);
        check("rs_rel_mem_wr", 32'(pif.MEM_WriteReg_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
